// File: rtl/car_motion_ctrl_if.sv
// Frame-tick request, player input levels and per-frame motion results for one car.
interface car_motion_ctrl_if #(
  parameter int DECIMAL_WIDTH = 6,
  parameter int ANG_WIDTH     = 8
);
  logic                            i_frame_tick;
  logic                            i_left;
  logic                            i_right;
  logic                            i_throttle;
  logic                            i_brake;
  logic [ANG_WIDTH:0]              o_angle;
  logic [DECIMAL_WIDTH+1:0]        o_speed;
  logic signed [DECIMAL_WIDTH+2:0] o_v_x;
  logic signed [DECIMAL_WIDTH+2:0] o_v_y;
  logic                            o_valid;
  logic                            o_busy;
  logic                            o_drop;

  modport master (
    output i_frame_tick, i_left, i_right, i_throttle, i_brake,
    input  o_angle, o_speed, o_v_x, o_v_y, o_valid, o_busy, o_drop
  );

  modport slave (
    input  i_frame_tick, i_left, i_right, i_throttle, i_brake,
    output o_angle, o_speed, o_v_x, o_v_y, o_valid, o_busy, o_drop
  );
endinterface

// File: rtl/car_motion_ctrl.sv
// Per-frame player motion: steer and pedal update, then project speed onto heading
// with one shared signed multiplier to produce the Q.6 velocity vector.
//
//   state  | meaning
//   IDLE   | waiting for a frame tick; inputs latched on acceptance
//   STEER  | heading index, turn counter and speed updated
//   MUL_X  | px = speed * cos(idx) registered
//   MUL_Y  | py = speed * sin(idx) registered
//   COMMIT | rounded velocity, angle and speed published, o_valid pulsed
module car_motion_ctrl #(
  parameter int DECIMAL_WIDTH = 6,
  parameter int ANG_WIDTH     = 8,
  parameter int INIT_DIR      = 0,
  parameter int TURN_DIV      = 4,
  parameter int V_MAX         = 96,
  parameter int ACCEL         = 2,
  parameter int DECEL         = 1,
  parameter int BRAKE         = 4
) (
  input logic           i_render_clk,
  input logic           i_rst,
  car_motion_ctrl_if.slave bus
);

  localparam int SW = 2 + DECIMAL_WIDTH;
  localparam int VW = 3 + DECIMAL_WIDTH;
  localparam int AW = ANG_WIDTH + 1;
  localparam int CW = 8;
  localparam int PW = SW + 1 + CW;
  localparam int TW = (TURN_DIV > 1) ? $clog2(TURN_DIV) : 1;

  localparam logic [4:0]           IDX_INIT   = 5'(INIT_DIR);
  localparam logic [4:0]           IDX_LAST   = 5'd23;
  localparam logic [TW-1:0]        TCNT_LAST  = TW'(TURN_DIV - 1);
  localparam logic [SW-1:0]        VMAX_S     = SW'(V_MAX);
  localparam logic [SW-1:0]        ACCEL_S    = SW'(ACCEL);
  localparam logic [SW-1:0]        DECEL_S    = SW'(DECEL);
  localparam logic [SW-1:0]        BRAKE_S    = SW'(BRAKE);
  localparam logic [AW-1:0]        ANGLE_INIT = AW'(INIT_DIR * 15);
  localparam logic signed [PW-1:0] HALF       = PW'(2 ** (DECIMAL_WIDTH - 1));

  typedef enum logic [2:0] {
    IDLE,
    STEER,
    MUL_X,
    MUL_Y,
    COMMIT
  } state_t;

  state_t state, state_nxt;

  logic                 lat_left, lat_right, lat_throttle, lat_brake;
  logic [4:0]           idx, idx_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [SW-1:0]        speed, speed_nxt;
  logic signed [PW-1:0] px, py, prod;
  logic signed [PW-1:0] rx, ry;
  logic signed [CW-1:0] coef;
  logic [5:0]           sin_sum;
  logic [4:0]           sin_idx;
  logic [SW:0]          spd_up;

  logic [AW-1:0]        angle_q;
  logic [SW-1:0]        speed_q;
  logic signed [VW-1:0] vx_q, vy_q;
  logic                 valid_q, drop_q;

  // Q.6 cosine for the first quadrant, 15 degree steps.
  function automatic logic signed [CW-1:0] cos_base(input logic [2:0] k);
    logic signed [CW-1:0] r;
    case (k)
      3'd0:    r = 8'sd64;
      3'd1:    r = 8'sd62;
      3'd2:    r = 8'sd55;
      3'd3:    r = 8'sd45;
      3'd4:    r = 8'sd32;
      3'd5:    r = 8'sd17;
      default: r = 8'sd0;
    endcase
    return r;
  endfunction

  function automatic logic signed [CW-1:0] cos_q6(input logic [4:0] i);
    logic signed [CW-1:0] r;
    if (i <= 5'd6)       r = cos_base(i[2:0]);
    else if (i <= 5'd12) r = -cos_base(3'(5'd12 - i));
    else if (i <= 5'd18) r = -cos_base(3'(i - 5'd12));
    else                 r = cos_base(3'(5'd24 - i));
    return r;
  endfunction

  always_ff @(posedge i_render_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_frame_tick) state_nxt = STEER;
      STEER:   state_nxt = MUL_X;
      MUL_X:   state_nxt = MUL_Y;
      MUL_Y:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Heading, turn-rate counter and speed for the STEER step.
  always_comb begin
    idx_nxt   = idx;
    tcnt_nxt  = '0;
    speed_nxt = speed;
    spd_up    = {1'b0, speed} + {1'b0, ACCEL_S};
    if (lat_left ^ lat_right) begin
      tcnt_nxt = (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;
      if (tcnt == '0) begin
        if (lat_left) idx_nxt = (idx == IDX_LAST) ? 5'd0 : idx + 5'd1;
        else          idx_nxt = (idx == 5'd0) ? IDX_LAST : idx - 5'd1;
      end
    end
    if (lat_brake)
      speed_nxt = (speed >= BRAKE_S) ? speed - BRAKE_S : '0;
    else if (lat_throttle)
      speed_nxt = (spd_up > {1'b0, VMAX_S}) ? VMAX_S : spd_up[SW-1:0];
    else
      speed_nxt = (speed >= DECEL_S) ? speed - DECEL_S : '0;
  end

  // sin(idx) = cos(idx - 6 mod 24) = cos(idx + 18 mod 24)
  assign sin_sum = {1'b0, idx} + 6'd18;
  assign sin_idx = (sin_sum >= 6'd24) ? 5'(sin_sum - 6'd24) : sin_sum[4:0];
  assign coef    = cos_q6((state == MUL_X) ? idx : sin_idx);
  assign prod    = $signed({1'b0, speed}) * coef;

  // Round half toward +inf; the slice is the arithmetic shift right by DECIMAL_WIDTH.
  assign rx = px + HALF;
  assign ry = py + HALF;

  always_ff @(posedge i_render_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_left     <= 1'b0;
      lat_right    <= 1'b0;
      lat_throttle <= 1'b0;
      lat_brake    <= 1'b0;
      idx          <= IDX_INIT;
      tcnt         <= '0;
      speed        <= '0;
      px           <= '0;
      py           <= '0;
      angle_q      <= ANGLE_INIT;
      speed_q      <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      drop_q  <= bus.i_frame_tick && (state != IDLE);
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_frame_tick) begin
            lat_left     <= bus.i_left;
            lat_right    <= bus.i_right;
            lat_throttle <= bus.i_throttle;
            lat_brake    <= bus.i_brake;
          end
        end
        STEER: begin
          idx   <= idx_nxt;
          tcnt  <= tcnt_nxt;
          speed <= speed_nxt;
        end
        MUL_X: px <= prod;
        MUL_Y: py <= prod;
        COMMIT: begin
          angle_q <= AW'(idx) * AW'(15);
          speed_q <= speed;
          vx_q    <= rx[DECIMAL_WIDTH +: VW];
          vy_q    <= ry[DECIMAL_WIDTH +: VW];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_angle = angle_q;
  assign bus.o_speed = speed_q;
  assign bus.o_v_x   = vx_q;
  assign bus.o_v_y   = vy_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_drop  = drop_q;

endmodule
